// File: rtl/onehot_mask_decoder_pkg.sv
// rtl/onehot_mask_decoder_pkg.sv - shared constants and state type for the one-hot mask decoder
// Purpose: the terminator code, the mask, index and count widths, and the frame
//          state enumeration used by onehot_mask_decoder and onehot_dec4.
// Ports:   none (package)
package onehot_mask_decoder_pkg;

  localparam logic [7:0] CODE_NONE = 8'hF0;
  localparam int         MASK_W    = 16;
  localparam int         IDX_W     = 4;
  localparam int         CNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/onehot_mask_decoder_dec4.sv
// rtl/onehot_mask_decoder_dec4.sv - 4-bit index to 16-bit one-hot decoder
// Purpose: combinational decode of a bit index into a word with only that bit set.
// Ports:   i_idx    - 4-bit bit index
//          o_onehot - 16-bit word with bit i_idx set, all others clear
module onehot_dec4
  import onehot_mask_decoder_pkg::*;
(
  input  logic [IDX_W-1:0]  i_idx,
  output logic [MASK_W-1:0] o_onehot
);

  localparam logic [MASK_W-1:0] ONE = {{(MASK_W-1){1'b0}}, 1'b1};

  assign o_onehot = ONE << i_idx;

endmodule

// File: rtl/onehot_mask_decoder.sv
// rtl/onehot_mask_decoder.sv - rebuilds a 16-bit mask from a frame of bit-index codes
// Purpose: accepts codes 0..15 (bit indices) terminated by 8'hF0 and presents the
//          reconstructed mask, its population count and an error flag for the frame.
// Ports:   clk, rst            - clock, asynchronous active-high reset
//          in_valid/in_ready   - input code handshake
//          in_code             - 8'd0..8'd15 bit index, 8'hF0 terminator
//          out_valid/out_ready - result handshake
//          out_mask            - reconstructed mask
//          out_count           - number of bits set in out_mask
//          out_err             - invalid, duplicate or (STRICT_ORDER) out-of-order code seen
module onehot_mask_decoder
  import onehot_mask_decoder_pkg::*;
#(
  parameter bit STRICT_ORDER = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MASK_W-1:0] out_mask,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_err
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [MASK_W-1:0]  r_mask;
  logic [MASK_W-1:0]  w_mask_nxt;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   w_last_nxt;
  logic               r_err;
  logic               w_err_nxt;

  logic [MASK_W-1:0]  w_onehot;
  logic               w_accept;
  logic               w_is_none;
  logic               w_is_invalid;
  logic               w_is_dup;
  logic               w_out_of_order;

  onehot_dec4 u_dec4 (
    .i_idx    (in_code[IDX_W-1:0]),
    .o_onehot (w_onehot)
  );

  // in_ready is gated by rst so nothing looks acceptable while reset is held.
  assign in_ready  = !rst && (r_state != DONE);
  assign w_accept  = in_valid && in_ready;

  assign w_is_none      = (in_code == CODE_NONE);
  assign w_is_invalid   = !w_is_none && (in_code[7:4] != 4'h0);
  assign w_is_dup       = (r_mask & w_onehot) != '0;
  // Order is only judged against a previous index; the first index of a frame is always in order.
  assign w_out_of_order = STRICT_ORDER && (r_count != '0) && (in_code[IDX_W-1:0] >= r_last);

  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_count_nxt = r_count;
    w_last_nxt  = r_last;
    w_err_nxt   = r_err;
    case (r_state)
      IDLE, ACCUM: begin
        if (w_accept) begin
          if (w_is_none) begin
            w_state_nxt = DONE;
          end else if (w_is_invalid) begin
            w_err_nxt = 1'b1;
          end else if (w_is_dup) begin
            // Duplicates never touch mask or count, which also bounds the count at 16.
            w_err_nxt = 1'b1;
          end else begin
            w_mask_nxt  = r_mask | w_onehot;
            w_count_nxt = r_count + 1'b1;
            w_last_nxt  = in_code[IDX_W-1:0];
            w_state_nxt = ACCUM;
            if (w_out_of_order) begin
              w_err_nxt = 1'b1;
            end
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
          w_mask_nxt  = '0;
          w_count_nxt = '0;
          w_last_nxt  = '0;
          w_err_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask  <= '0;
      r_count <= '0;
      r_last  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_mask  <= w_mask_nxt;
      r_count <= w_count_nxt;
      r_last  <= w_last_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Result fields come straight from the accumulators, which are frozen in DONE.
  assign out_valid = (r_state == DONE);
  assign out_mask  = r_mask;
  assign out_count = r_count;
  assign out_err   = r_err;

endmodule

// File: tb/tb_onehot_mask_decoder.sv
// tb/tb_onehot_mask_decoder.sv - self-checking bench for onehot_mask_decoder (strict and relaxed order)
module tb_onehot_mask_decoder;

  typedef logic [7:0] code_q_t[$];

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_code;
  logic        out_ready;

  logic        s_in_ready, s_out_valid, s_out_err;
  logic [15:0] s_out_mask;
  logic [4:0]  s_out_count;
  logic        l_in_ready, l_out_valid, l_out_err;
  logic [15:0] l_out_mask;
  logic [4:0]  l_out_count;

  int vectors     = 0;
  int miscompares = 0;

  onehot_mask_decoder #(.STRICT_ORDER(1'b1)) dut_s (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .in_code   (in_code),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_mask  (s_out_mask),
    .out_count (s_out_count),
    .out_err   (s_out_err)
  );

  onehot_mask_decoder #(.STRICT_ORDER(1'b0)) dut_l (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (l_in_ready),
    .in_code   (in_code),
    .out_valid (l_out_valid),
    .out_ready (out_ready),
    .out_mask  (l_out_mask),
    .out_count (l_out_count),
    .out_err   (l_out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the mask is the set of distinct valid indices; an error is any
  // code outside 0..15, any repeated index, or (strict) any index not below
  // the previously recorded index.
  task automatic model(input code_q_t codes, input bit strict,
                       output logic [15:0] mask, output logic [4:0] cnt, output logic err);
    int prev;
    mask = '0;
    err  = 1'b0;
    prev = -1;
    foreach (codes[i]) begin
      int c;
      c = int'(codes[i]);
      if (c > 15) begin
        err = 1'b1;
      end else if (mask[c]) begin
        err = 1'b1;
      end else begin
        if (strict && prev >= 0 && c >= prev) err = 1'b1;
        mask[c] = 1'b1;
        prev = c;
      end
    end
    cnt = 5'($countones(mask));
  endtask

  task automatic check_result(input string tag, input logic [15:0] m_s, input logic [4:0] c_s,
                              input logic e_s, input logic e_l);
    chk({tag, ".s_valid"}, 32'(s_out_valid), 32'(1));
    chk({tag, ".s_mask"},  32'(s_out_mask),  32'(m_s));
    chk({tag, ".s_count"}, 32'(s_out_count), 32'(c_s));
    chk({tag, ".s_err"},   32'(s_out_err),   32'(e_s));
    chk({tag, ".s_ready"}, 32'(s_in_ready),  32'(0));
    chk({tag, ".l_valid"}, 32'(l_out_valid), 32'(1));
    chk({tag, ".l_mask"},  32'(l_out_mask),  32'(m_s));
    chk({tag, ".l_count"}, 32'(l_out_count), 32'(c_s));
    chk({tag, ".l_err"},   32'(l_out_err),   32'(e_l));
    chk({tag, ".l_ready"}, 32'(l_in_ready),  32'(0));
  endtask

  task automatic run_frame(input string tag, input code_q_t codes, input int stall,
                           input bit use_exp, input logic [15:0] x_mask, input logic [4:0] x_cnt,
                           input logic x_err_s, input logic x_err_l);
    logic [15:0] m;
    logic [4:0]  c;
    logic        es, el;
    code_q_t     all;
    model(codes, 1'b1, m, c, es);
    model(codes, 1'b0, m, c, el);
    if (use_exp) begin
      chk({tag, ".ref_mask"}, 32'(m),  32'(x_mask));
      chk({tag, ".ref_cnt"},  32'(c),  32'(x_cnt));
      chk({tag, ".ref_errs"}, 32'(es), 32'(x_err_s));
      chk({tag, ".ref_errl"}, 32'(el), 32'(x_err_l));
    end
    all = codes;
    all.push_back(8'hF0);
    foreach (all[i]) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_code  = all[i];
      chk({tag, ".in_ready"}, 32'({s_in_ready, l_in_ready}), 32'(2'b11));
      chk({tag, ".no_valid"}, 32'({s_out_valid, l_out_valid}), 32'(2'b00));
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_code  = 8'h00;
    check_result({tag, ".lat1"}, m, c, es, el);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check_result({tag, ".hold"}, m, c, es, el);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".post_valid"}, 32'({s_out_valid, l_out_valid}), 32'(2'b00));
    chk({tag, ".post_ready"}, 32'({s_in_ready, l_in_ready}), 32'(2'b11));
  endtask

  initial begin
    code_q_t q;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_code   = 8'h00;
    out_ready = 1'b0;

    @(negedge clk);
    chk("rst.in_ready",  32'({s_in_ready, l_in_ready}),   32'(0));
    chk("rst.out_valid", 32'({s_out_valid, l_out_valid}), 32'(0));
    chk("rst.mask",      32'(s_out_mask | l_out_mask),    32'(0));
    chk("rst.count",     32'(s_out_count | l_out_count),  32'(0));
    chk("rst.err",       32'(s_out_err | l_out_err),      32'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle.in_ready", 32'({s_in_ready, l_in_ready}), 32'(2'b11));

    q = '{8'd15, 8'd3, 8'd0};
    run_frame("f_15_3_0", q, 0, 1'b1, 16'h8009, 5'd3, 1'b0, 1'b0);
    q = {};
    run_frame("f_empty", q, 0, 1'b1, 16'h0000, 5'd0, 1'b0, 1'b0);
    q = '{8'd5, 8'd9};
    run_frame("f_5_9", q, 0, 1'b1, 16'h0220, 5'd2, 1'b1, 1'b0);
    q = '{8'd7, 8'd7, 8'h20};
    run_frame("f_dup_inv", q, 0, 1'b1, 16'h0080, 5'd1, 1'b1, 1'b1);
    q = '{8'd15, 8'd3, 8'd0};
    run_frame("f_stall", q, 5, 1'b1, 16'h8009, 5'd3, 1'b0, 1'b0);
    q = '{8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'd10, 8'd9, 8'd8,
          8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd4};
    run_frame("f_full17", q, 0, 1'b1, 16'hFFFF, 5'd16, 1'b1, 1'b1);

    // Reset in the middle of a frame discards it.
    @(negedge clk);
    in_valid = 1'b1;
    in_code  = 8'd15;
    @(negedge clk);
    in_code  = 8'd14;
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("midrst.in_ready",  32'({s_in_ready, l_in_ready}),   32'(0));
    chk("midrst.out_valid", 32'({s_out_valid, l_out_valid}), 32'(0));
    chk("midrst.mask",      32'(s_out_mask | l_out_mask),    32'(0));
    chk("midrst.count",     32'(s_out_count | l_out_count),  32'(0));
    chk("midrst.err",       32'(s_out_err | l_out_err),      32'(0));
    @(negedge clk);
    rst = 1'b0;
    q = '{8'd2};
    run_frame("f_after_rst", q, 0, 1'b1, 16'h0004, 5'd1, 1'b0, 1'b0);

    for (int f = 0; f < 30; f++) begin
      int len;
      int nxt;
      q   = {};
      len = int'($urandom_range(0, 8));
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < len; i++) begin
          int r;
          r = int'($urandom_range(0, 9));
          if (r == 0)      q.push_back(8'($urandom_range(8'h10, 8'hEF)));
          else if (r == 1) q.push_back(8'($urandom_range(8'hF1, 8'hFF)));
          else             q.push_back(8'($urandom_range(0, 15)));
        end
      end else begin
        nxt = 15 - int'($urandom_range(0, 3));
        for (int i = 0; i < len && nxt >= 0; i++) begin
          q.push_back(8'(nxt));
          nxt = nxt - 1 - int'($urandom_range(0, 2));
        end
      end
      run_frame("f_rand", q, int'($urandom_range(0, 3)), 1'b0, '0, '0, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
